// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the fetch slice.
//   - icode constants (HALT..POPQ, JXX, CALL, RET, NOP)
//   - stat codes (AOK, HLT, ADR, INS)
//   - fetch FSM state enum (RUN, DRAIN, STOPPED)
//   - decode pipeline register record, its bubble value, and
//     instruction-length helper functions
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    STOPPED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t DBubble = '{
    valid: 1'b0, stat: AOK, icode: NOP, ifun: 4'h0,
    ra: 4'h0, rb: 4'h0, valc: 64'h0, valp: 64'h0
  };

  function automatic logic need_regids(input logic [3:0] icode);
    case (icode)
      RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ: need_regids = 1'b1;
      default:                                          need_regids = 1'b0;
    endcase
  endfunction

  function automatic logic need_valc(input logic [3:0] icode);
    case (icode)
      IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL: need_valc = 1'b1;
      default:                           need_valc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode: combinational split of the fetched bytes into fields.
// Ports:
//   f_pc_i       fetch address
//   f_ibyte_i    byte at f_pc (icode:ifun)
//   f_ibytes_i   next nine bytes, byte f_pc+1 in [71:64]
//   imem_error_i memory reported a bad access
//   icode_o/ifun_o/ra_o/rb_o/valc_o/valp_o  decoded fields
//   stat_o       status of this fetch (AOK/HLT/ADR/INS)
module fetch_predecode
  import y86_pkg::*;
#(
  parameter logic [63:0] IMEM_LAST = 64'd1024
) (
  input  logic [63:0] f_pc_i,
  input  logic [7:0]  f_ibyte_i,
  input  logic [71:0] f_ibytes_i,
  input  logic        imem_error_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [2:0]  stat_o,
  output logic [63:0] valc_o,
  output logic [63:0] valp_o
);

  logic addr_err;
  logic regids;
  logic valc_present;

  assign addr_err = imem_error_i || (f_pc_i > IMEM_LAST);

  always_comb begin
    icode_o = f_ibyte_i[7:4];
    ifun_o  = f_ibyte_i[3:0];
    stat_o  = AOK;
    if (addr_err) begin
      // A bad address is turned into a harmless NOP carrying ADR status.
      icode_o = NOP;
      ifun_o  = 4'h0;
      stat_o  = ADR;
    end else if (icode_o > POPQ) begin
      stat_o = INS;
    end else if (icode_o == HALT) begin
      stat_o = HLT;
    end
  end

  assign regids       = need_regids(icode_o);
  assign valc_present = need_valc(icode_o);

  assign ra_o   = f_ibytes_i[71:68];
  assign rb_o   = f_ibytes_i[67:64];
  assign valc_o = regids ? f_ibytes_i[63:0] : f_ibytes_i[71:8];
  assign valp_o = f_pc_i + 64'd1 + {63'd0, regids} + (valc_present ? 64'd8 : 64'd0);

endmodule

// File: rtl/fetch_control.sv
// fetch_control: Y86-64 fetch stage with PC selection, decode pipeline
// register and a RUN/DRAIN/STOPPED control FSM.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   F_stall, D_stall, D_bubble   hazard controls
//   M_icode, M_Cnd, M_valA       branch resolution (mispredict redirect)
//   W_icode, W_valM, W_stat      return redirect and commit status
//   f_pc                         combinational fetch address
//   f_ibyte, f_ibytes, imem_error  instruction memory return
//   D_*                          decode pipeline register
//   fetch_state, halted          FSM state, high in STOPPED
//   fetch_count, stall_count     performance counters
// Build option: FETCH_PERF_CNT_EN enables the counters; otherwise they read 0.
module fetch_control
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] IMEM_LAST = 64'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [2:0]  W_stat,
  output logic [63:0] f_pc,
  input  logic [7:0]  f_ibyte,
  input  logic [71:0] f_ibytes,
  input  logic        imem_error,
  output logic        D_valid,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [1:0]  fetch_state,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pred_pc_q, pred_pc_d;
  d_reg_t       d_q, d_d;

  logic         mispredict;
  logic         ret_redirect;
  logic         redirect;
  logic         fetch_active;
  logic         load_fetch;

  logic [3:0]   f_icode, f_ifun, f_ra, f_rb;
  logic [2:0]   f_stat;
  logic [63:0]  f_valc, f_valp;
  d_reg_t       fetched;

  assign mispredict   = (M_icode == JXX) && !M_Cnd;
  assign ret_redirect = (W_icode == RET);
  assign redirect     = mispredict || ret_redirect;

  always_comb begin
    if (mispredict) begin
      f_pc = M_valA;
    end else if (ret_redirect) begin
      f_pc = W_valM;
    end else begin
      f_pc = pred_pc_q;
    end
  end

  fetch_predecode #(
    .IMEM_LAST(IMEM_LAST)
  ) u_predecode (
    .f_pc_i      (f_pc),
    .f_ibyte_i   (f_ibyte),
    .f_ibytes_i  (f_ibytes),
    .imem_error_i(imem_error),
    .icode_o     (f_icode),
    .ifun_o      (f_ifun),
    .ra_o        (f_ra),
    .rb_o        (f_rb),
    .stat_o      (f_stat),
    .valc_o      (f_valc),
    .valp_o      (f_valp)
  );

  assign fetched = '{
    valid: 1'b1, stat: f_stat, icode: f_icode, ifun: f_ifun,
    ra: f_ra, rb: f_rb, valc: f_valc, valp: f_valp
  };

  // In DRAIN a redirect re-opens fetch in the same cycle, unless the
  // writeback stage is committing a fault, which wins.
  assign fetch_active = (state_q == RUN) ||
                        ((state_q == DRAIN) && redirect && (W_stat == AOK));
  assign load_fetch   = fetch_active && !D_bubble && !D_stall;

  always_comb begin
    d_d = d_q;
    if (D_bubble) begin
      d_d = DBubble;
    end else if (!D_stall) begin
      d_d = fetch_active ? fetched : DBubble;
    end
  end

  always_comb begin
    pred_pc_d = pred_pc_q;
    if (fetch_active && !F_stall) begin
      pred_pc_d = ((f_icode == JXX) || (f_icode == CALL)) ? f_valc : f_valp;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (load_fetch && (f_stat != AOK)) state_d = DRAIN;
      end
      DRAIN: begin
        if (W_stat != AOK) begin
          state_d = STOPPED;
        end else if (redirect) begin
          state_d = (load_fetch && (f_stat != AOK)) ? DRAIN : RUN;
        end
      end
      STOPPED: state_d = STOPPED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pred_pc_q <= RESET_PC;
      d_q       <= DBubble;
    end else begin
      state_q   <= state_d;
      pred_pc_q <= pred_pc_d;
      d_q       <= d_d;
    end
  end

  assign D_valid     = d_q.valid;
  assign D_stat      = d_q.stat;
  assign D_icode     = d_q.icode;
  assign D_ifun      = d_q.ifun;
  assign D_rA        = d_q.ra;
  assign D_rB        = d_q.rb;
  assign D_valC      = d_q.valc;
  assign D_valP      = d_q.valp;
  assign fetch_state = state_q;
  assign halted      = (state_q == STOPPED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (load_fetch && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (F_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: byte-array instruction memory, a vector table
// of straight-line fetches checked through a scoreboard queue, then
// hand-written sequences for redirects, drain/stop, stalls and ranges.
module tb_fetch_control;
  import y86_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [2:0]  W_stat;
  logic [63:0] f_pc;
  logic [7:0]  f_ibyte;
  logic [71:0] f_ibytes;
  logic        imem_error;
  logic        D_valid;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0]  fetch_state;
  logic        halted;
  logic [31:0] fetch_count, stall_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:2047];

  fetch_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .M_icode    (M_icode),
    .M_Cnd      (M_Cnd),
    .M_valA     (M_valA),
    .W_icode    (W_icode),
    .W_valM     (W_valM),
    .W_stat     (W_stat),
    .f_pc       (f_pc),
    .f_ibyte    (f_ibyte),
    .f_ibytes   (f_ibytes),
    .imem_error (imem_error),
    .D_valid    (D_valid),
    .D_stat     (D_stat),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP),
    .fetch_state(fetch_state),
    .halted     (halted),
    .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: byte at f_pc and the following nine bytes.
  always_comb begin
    logic [10:0] idx;
    f_ibyte  = mem[f_pc[10:0]];
    f_ibytes = '0;
    for (int i = 0; i < 9; i++) begin
      idx = f_pc[10:0] + 11'(i + 1);
      f_ibytes[71 - 8*i -: 8] = mem[idx];
    end
  end

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put64(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[a + i] = v[63 - 8*i -: 8];
  endtask

  task automatic idle();
    F_stall    = 1'b0;
    D_stall    = 1'b0;
    D_bubble   = 1'b0;
    M_icode    = NOP;
    M_Cnd      = 1'b1;
    M_valA     = 64'h0;
    W_icode    = NOP;
    W_valM     = 64'h0;
    W_stat     = AOK;
    imem_error = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic mispredict_to(input logic [63:0] a);
    M_icode = JXX;
    M_Cnd   = 1'b0;
    M_valA  = a;
    #1;
  endtask

  initial begin
    vec_t e;
    int   bad;

    for (int i = 0; i < 2048; i++) mem[i] = 8'h10;
    mem[8'h00] = 8'h30; mem[8'h01] = 8'hF2; put64(32'h02, 64'h1122334455667788);
    mem[8'h0A] = 8'h20; mem[8'h0B] = 8'h31;
    mem[8'h0C] = 8'h61; mem[8'h0D] = 8'h45;
    mem[8'h0E] = 8'h73; put64(32'h0F, 64'h30);
    mem[8'h20] = 8'h70; put64(32'h21, 64'h100);
    mem[8'h30] = 8'h80; put64(32'h31, 64'h50);
    mem[8'h40] = 8'h00;
    mem[8'h50] = 8'h10; mem[8'h51] = 8'h50; mem[8'h52] = 8'hA3; put64(32'h53, 64'h8);
    mem[8'h5B] = 8'hA0; mem[8'h5C] = 8'h2F;
    mem[8'h70] = 8'hC0;

    vecs[0] = '{64'h00, 4'h3, 4'h0, 4'hF, 4'h2, 64'h1122334455667788, 64'h0A};
    vecs[1] = '{64'h0A, 4'h2, 4'h0, 4'h3, 4'h1, 64'h6145730000000000, 64'h0C};
    vecs[2] = '{64'h0C, 4'h6, 4'h1, 4'h4, 4'h5, 64'h7300000000000000, 64'h0E};
    vecs[3] = '{64'h0E, 4'h7, 4'h3, 4'h0, 4'h0, 64'h30, 64'h17};
    vecs[4] = '{64'h30, 4'h8, 4'h0, 4'h0, 4'h0, 64'h50, 64'h39};
    vecs[5] = '{64'h50, 4'h1, 4'h0, 4'h5, 4'h0, 64'h50A3000000000000, 64'h51};
    vecs[6] = '{64'h51, 4'h5, 4'h0, 4'hA, 4'h3, 64'h08, 64'h5B};
    vecs[7] = '{64'h5B, 4'hA, 4'h0, 4'h2, 4'hF, 64'h1010101010101010, 64'h5D};

    // Reset state
    do_reset();
    chk("rst_valid", 64'(D_valid), 64'd0);
    chk("rst_icode", 64'(D_icode), 64'(NOP));
    chk("rst_stat", 64'(D_stat), 64'(AOK));
    chk("rst_state", 64'(fetch_state), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fpc", f_pc, 64'h0);
    chk("rst_fcnt", 64'(fetch_count), 64'd0);
    chk("rst_scnt", 64'(stall_count), 64'd0);

    // Straight-line program, predicted PC follows valP / jump and call targets
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_fpc", i), f_pc, vecs[i].pc);
      sb.push_back(vecs[i]);
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", i), 64'(D_valid), 64'd1);
      chk($sformatf("v%0d_stat", i), 64'(D_stat), 64'(AOK));
      chk($sformatf("v%0d_icode", i), 64'(D_icode), 64'(e.icode));
      chk($sformatf("v%0d_ifun", i), 64'(D_ifun), 64'(e.ifun));
      chk($sformatf("v%0d_ra", i), 64'(D_rA), 64'(e.ra));
      chk($sformatf("v%0d_rb", i), 64'(D_rB), 64'(e.rb));
      chk($sformatf("v%0d_valc", i), D_valC, e.valc);
      chk($sformatf("v%0d_valp", i), D_valP, e.valp);
    end
    chk("table_state", 64'(fetch_state), 64'd0);

    // Jump target prediction then mispredict redirect
    do_reset();
    mispredict_to(64'h20);
    chk("jxx_fpc", f_pc, 64'h20);
    tick(); idle(); #1;
    chk("jxx_icode", 64'(D_icode), 64'h7);
    chk("jxx_pred", f_pc, 64'h100);
    mispredict_to(64'h29);
    chk("misp_fpc", f_pc, 64'h29);
    tick(); idle(); #1;
    chk("misp_icode", 64'(D_icode), 64'(NOP));
    chk("misp_valp", D_valP, 64'h2A);
    chk("misp_next", f_pc, 64'h2A);

    // HALT via return redirect, drain, stop, hold, reset out
    do_reset();
    W_icode = RET; W_valM = 64'h40; #1;
    chk("ret_fpc", f_pc, 64'h40);
    tick(); idle(); #1;
    chk("halt_state", 64'(fetch_state), 64'd1);
    chk("halt_stat", 64'(D_stat), 64'(HLT));
    chk("halt_valid", 64'(D_valid), 64'd1);
    chk("halt_fpc", f_pc, 64'h41);
    tick();
    chk("drain_bubble", 64'(D_valid), 64'd0);
    chk("drain_pchold", f_pc, 64'h41);
    W_stat = HLT;
    tick(); idle();
    chk("stop_state", 64'(fetch_state), 64'd2);
    chk("stop_halted", 64'(halted), 64'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 3) mispredict_to(64'h0); else idle();
      tick();
      if (halted !== 1'b1 || D_valid !== 1'b0 || fetch_state !== 2'd2) bad++;
    end
    chk("stop_hold100", 64'(bad), 64'd0);
    do_reset();
    chk("stop_rst_state", 64'(fetch_state), 64'd0);
    chk("stop_rst_halted", 64'(halted), 64'd0);
    chk("stop_rst_fpc", f_pc, 64'h0);

    // Wrong-path HALT, redirect in DRAIN resumes fetch
    do_reset();
    mispredict_to(64'h40);
    tick(); idle(); tick();
    chk("wp_drain", 64'(fetch_state), 64'd1);
    mispredict_to(64'h0);
    chk("wp_redir_fpc", f_pc, 64'h0);
    tick(); idle(); #1;
    chk("wp_run", 64'(fetch_state), 64'd0);
    chk("wp_valid", 64'(D_valid), 64'd1);
    chk("wp_icode", 64'(D_icode), 64'h3);
    chk("wp_next", f_pc, 64'h0A);

    // Fault commit and redirect together in DRAIN: stop wins
    do_reset();
    mispredict_to(64'h40);
    tick(); idle();
    mispredict_to(64'h0);
    W_stat = HLT;
    tick(); idle();
    chk("both_state", 64'(fetch_state), 64'd2);
    chk("both_valid", 64'(D_valid), 64'd0);

    // D_stall hold, D_bubble beats D_stall
    do_reset();
    tick();
    chk("ds_loaded", 64'(D_valid), 64'd1);
    D_stall = 1'b1;
    tick();
    chk("ds_hold", 64'(D_icode), 64'h3);
    D_bubble = 1'b1;
    tick(); idle();
    chk("db_valid", 64'(D_valid), 64'd0);
    chk("db_icode", 64'(D_icode), 64'(NOP));

    // F_stall for three cycles keeps the fetch PC
    do_reset();
    F_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fs_pc%0d", i), f_pc, 64'h0);
    end
    idle(); #1;
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_count), 64'd3);
    chk("fetch_cnt", 64'(fetch_count), 64'd3);
    D_stall = 1'b1;
    tick(); idle();
    chk("fetch_cnt_hold", 64'(fetch_count), 64'd3);
`else
    chk("stall_cnt_off", 64'(stall_count), 64'd0);
    chk("fetch_cnt_off", 64'(fetch_count), 64'd0);
`endif

    // Address range boundary and memory error
    do_reset();
    mispredict_to(64'd1025);
    tick(); idle(); #1;
    chk("adr_stat", 64'(D_stat), 64'(ADR));
    chk("adr_icode", 64'(D_icode), 64'(NOP));
    chk("adr_ifun", 64'(D_ifun), 64'd0);
    chk("adr_state", 64'(fetch_state), 64'd1);
    do_reset();
    mispredict_to(64'd1024);
    tick(); idle(); #1;
    chk("last_stat", 64'(D_stat), 64'(AOK));
    chk("last_valp", D_valP, 64'd1025);
    chk("last_state", 64'(fetch_state), 64'd0);
    do_reset();
    imem_error = 1'b1;
    tick(); idle();
    chk("imerr_stat", 64'(D_stat), 64'(ADR));

    // Invalid instruction
    do_reset();
    mispredict_to(64'h70);
    tick(); idle();
    chk("ins_stat", 64'(D_stat), 64'(INS));
    chk("ins_icode", 64'(D_icode), 64'hC);
    chk("ins_state", 64'(fetch_state), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded into the predicted-PC register at reset.
REQ-002 Parameter IMEM_LAST, default 1024, highest valid instruction-memory byte address; used for the fetch address-range check.
REQ-003 clk  in  1  single rising-edge clock for all state.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 F_stall, D_stall, D_bubble  in  1 each  pipeline-control hazard signals.
REQ-006 M_icode  in  4, M_Cnd  in  1, M_valA  in  64  memory-stage branch-resolution inputs.
REQ-007 W_icode  in  4, W_valM  in  64, W_stat  in  3  writeback-stage return-address and commit-status inputs.
REQ-008 f_pc  out  64  combinational fetch address to instruction memory.
REQ-009 f_ibyte  in  8, f_ibytes  in  72, imem_error  in  1  instruction-memory return, valid in the same cycle as f_pc.
REQ-010 D_valid 1, D_stat 3, D_icode 4, D_ifun 4, D_rA 4, D_rB 4, D_valC 64, D_valP 64  out  decode pipeline register.
REQ-011 fetch_state  out  2  FSM state; halted  out  1  high in STOPPED.
REQ-012 fetch_count  out  32, stall_count  out  32  performance counters.

Function
REQ-013 f_pc priority: M_icode==JXX && !M_Cnd -> M_valA; else W_icode==RET -> W_valM; else predPC.
REQ-014 Redirect = either of the first two REQ-013 conditions.
REQ-015 imem_error or f_pc>IMEM_LAST -> icode NOP(1), ifun 0, f_stat ADR(3).
REQ-016 icode>4'hB -> f_stat INS(4); icode HALT(0) -> HLT(2); else AOK(1).
REQ-017 need_regids for icode {2,3,4,5,6,A,B}; need_valC for {3,4,5,7,8}.
REQ-018 rA/rB = f_ibytes[71:68]/[67:64]; valC = need_regids ? f_ibytes[63:0] : f_ibytes[71:8].
REQ-019 valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit modulo wrap.
REQ-020 Next predPC = valC for JXX or CALL; else valP; register loads only when !F_stall.
REQ-021 D register: D_bubble -> D_valid 0, icode NOP, ifun 0, stat AOK, other fields 0; else D_stall -> hold; else load fetched fields, D_valid 1. D_bubble has priority over D_stall.
REQ-022 FSM RUN(0): a non-AOK instruction loaded into D -> DRAIN(1).
REQ-023 DRAIN: D loads a bubble every cycle unless D_stall; predPC holds. Redirect -> RUN (fetch proceeds from redirected f_pc that cycle). W_stat!=AOK -> STOPPED(2). Simultaneous W_stat!=AOK and redirect -> STOPPED.
REQ-024 STOPPED: D loads bubbles, predPC holds, halted=1; exit only by reset.
REQ-025 All fetched-field outputs are registered; fetch-to-D latency is one cycle.

Reset
REQ-026 On rising clk with rst_n=0: predPC=RESET_PC, FSM=RUN, D register = bubble value (REQ-021), counters=0, halted=0.
REQ-027 Reset asserted mid-DRAIN or in STOPPED returns to RUN on the next edge with no residual state.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments per cycle D loads with D_valid=1; stall_count increments per cycle F_stall=1; both saturate at 32'hFFFFFFFF.
- Undefined: no counter registers; both ports are constant 0.

Structure
REQ-029 Package y86_pkg holds the icode constants (HALT..POPQ, JXX, CALL, RET, NOP) and the stat codes (AOK, HLT, ADR, INS).
REQ-030 The same package holds the fetch-state enum RUN/DRAIN/STOPPED.
REQ-031 Combinational sub-module fetch_predecode implements REQ-015..REQ-019.

Verification
REQ-032 Reset, then irmovq (30 F2 + 8-byte imm) at 0 -> next edge: D_icode=3, D_rB=2, D_valP=10, predPC=10.
REQ-033 jXX at 0x20 with target 0x100, later M_icode=7 and M_Cnd=0 with M_valA=0x29 -> f_pc=0x29 that cycle.
REQ-034 HALT byte at 0x40 -> fetch_state=DRAIN, then bubbles; W_stat=HLT -> STOPPED and halted=1 held for 100 cycles.
REQ-035 HALT fetched on wrong path, then redirect in DRAIN -> RUN, valid fetch resumes from the redirect PC.
REQ-036 D_stall and D_bubble both high -> D_valid=0. F_stall high for 3 cycles -> predPC unchanged; with FETCH_PERF_CNT_EN, stall_count=3.
REQ-037 f_pc=1025 -> D_stat=ADR, D_icode=NOP, FSM enters DRAIN.
